// File: rtl/i2c_pkg.sv
// Shared definitions for the write-only I2C target.
//   i2c_state_e : receive FSM states
//   I2C_ADDR_W  : target address width
//   I2C_DATA_W  : data byte width
//   RW_WRITE    : value of the R/W bit for a master write
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam logic        RW_WRITE   = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for one raw I2C line (SCL or SDA).
// A 2-FF synchronizer (preset to the idle-bus level 1), an optional glitch
// filter, then one edge-detect register producing single-cycle strobes.
// Optional feature macro: I2C_SLAVE_FILTER_EN (filter present when defined).
// Ports:
//   clk     in  system clock
//   arst    in  asynchronous reset, active high
//   line_i  in  raw bus line
//   level_o out conditioned line level
//   rise_o  out one-cycle strobe on a 0->1 transition of level_o
//   fall_o  out one-cycle strobe on a 1->0 transition of level_o
module i2c_line_sync #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (FILTER_LEN == 0) begin : g_len_check
    $error("i2c_line_sync: FILTER_LEN must be at least 1");
  end

  logic [1:0] sync_q, sync_d;
  logic       level;
  logic       level_q, level_d;

  always_comb sync_d = {sync_q[0], line_i};

`ifdef I2C_SLAVE_FILTER_EN
  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILTER_LEN-th such sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb level = filt_q;
`else
  always_comb level = sync_q[1];
`endif

  always_comb level_d = level;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q  <= '1;
      level_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    level_o = level;
    rise_o  = level & ~level_q;
    fall_o  = ~level & level_q;
  end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target. Oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address, receives data bytes, ACKs them and emits them on AXI-Stream.
// Optional feature macro: I2C_SLAVE_FILTER_EN (glitch filter in i2c_line_sync).
// Ports:
//   clk, arst      system clock / async active-high reset
//   i2c_scl        raw SCL
//   i2c_sda_i      raw SDA
//   i2c_sda_oe     1 = pull SDA low (ACK)
//   m_axis_*       received bytes; tuser=1 marks first byte after address
//   busy           1 from matched address ACK until STOP / repeated START
//   overflow       one-cycle pulse when a byte is NACKed because output is full
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
  parameter int unsigned           FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i2c_scl,
  input  logic                  i2c_sda_i,
  output logic                  i2c_sda_oe,
  output logic [I2C_DATA_W-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overflow
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
    .clk     (clk),
    .arst    (arst),
    .line_i  (i2c_scl),
    .level_o (scl_level),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
    .clk     (clk),
    .arst    (arst),
    .line_i  (i2c_sda_i),
    .level_o (sda_level),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // Both lines share the same latency, so SCL's current level qualifies SDA edges.
  logic start_det, stop_det;
  always_comb begin
    start_det = sda_fall & scl_level;
    stop_det  = sda_rise & scl_level;
  end

  i2c_state_e state_q, state_d;

  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  busy_q, busy_d;
  logic                  first_q, first_d;
  logic [I2C_DATA_W-1:0] tdata_q, tdata_d;
  logic                  tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ovf_q, ovf_d;

  logic addr_match, can_load, shifting;

  always_comb begin
    addr_match = (shift_q[I2C_DATA_W-1:1] == SLAVE_ADDR) && (shift_q[0] == RW_WRITE);
    can_load   = ~tvalid_q | m_axis_tready;
    shifting   = (state_q == ADDR) || (state_q == DATA);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR:     if (full_q) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_d = DATA;
        DATA:     if (full_q) state_d = can_load ? DATA_ACK : IGNORE;
        DATA_ACK: state_d = DATA;
        default:  state_d = state_q;
      endcase
    end
  end

  // Decoded straight from state so an async reset releases SDA immediately.
  always_comb begin
    i2c_sda_oe = (state_q == ADDR_ACK) || (state_q == DATA_ACK);
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    busy_d   = busy_q;
    first_d  = first_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    ovf_d    = 1'b0;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    if (start_det || stop_det) begin
      cnt_d  = '0;
      full_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      // full_q marks 8 bits received while the counter has wrapped back to 0.
      if (scl_rise && shifting && !full_q) begin
        shift_d = {shift_q[I2C_DATA_W-2:0], sda_level};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) full_d = 1'b1;
      end
      if (scl_fall) begin
        unique case (state_q)
          ADDR: begin
            if (full_q) begin
              full_d = 1'b0;
              cnt_d  = '0;
            end
          end
          ADDR_ACK: begin
            busy_d  = 1'b1;
            first_d = 1'b1;
          end
          DATA: begin
            if (full_q) begin
              full_d = 1'b0;
              cnt_d  = '0;
              if (can_load) begin
                tdata_d  = shift_q;
                tuser_d  = first_q;
                tvalid_d = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
          DATA_ACK: first_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      first_q  <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      first_q  <= first_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    m_axis_tdata  = tdata_q;
    m_axis_tuser  = tuser_q;
    m_axis_tvalid = tvalid_q;
    busy          = busy_q;
    overflow      = ovf_q;
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master model, transaction-level
// reference model feeding an expected-beat queue, and a monitor that checks
// AXIS beats, overflow pulses and when SDA is driven.
module tb_i2c_slave_rx;

  localparam int Q = 10; // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       arst;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] tdata;
  logic       tuser;
  logic       tvalid;
  logic       tready;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk           (clk),
    .arst          (arst),
    .i2c_scl       (scl),
    .i2c_sda_i     (sda_line),
    .i2c_sda_oe    (sda_oe),
    .m_axis_tdata  (tdata),
    .m_axis_tuser  (tuser),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .overflow      (overflow)
  );

  typedef struct {
    logic [7:0] data;
    logic       user;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ovf_seen = 0;
  int    exp_ovf  = 0;
  logic  pending  = 1'b0; // model: a beat is sitting in the DUT output register
  logic  ack_win  = 1'b0; // master is in an ACK slot where SDA may be pulled
  logic  glitch_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every accepted beat.
  always @(negedge clk) begin
    if (!arst) begin
      if (overflow) ovf_seen++;
      if (sda_oe) check("sda_oe_outside_ack_slot", ack_win, 1);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, tdata}, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_tdata", tdata, b.data);
          check("beat_tuser", tuser, b.user);
        end
      end
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; wq();
      scl   = 1'b1; wq();
    end
    sda_m = 1'b0; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = v[7-i];
      wq();
      if (glitch_next && i == 3) begin
        glitch_next = 1'b0;
        scl = 1'b1;
        @(posedge clk); #1;
        scl = 1'b0;
        wq();
      end
      scl = 1'b1; wq(); wq();
      if (n == 8 && i == 7) ack_win = 1'b1;
      scl = 1'b0; wq();
    end
  endtask

  task automatic ack_bit(output logic ack);
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    ack   = ~sda_line;
    wq();
    scl   = 1'b0; wq();
    ack_win = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    send_bits(v, 8);
    ack_bit(ack);
  endtask

  // One complete write transaction; the reference model decides every ACK,
  // every delivered beat and every overflow from the transfer-level rules.
  task automatic do_write(input logic [6:0] a, input logic rw, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2, input int n,
                          input logic rdy);
    logic [7:0] d[3];
    logic       ack, addr_ok, ign, ea;
    d[0] = d0; d[1] = d1; d[2] = d2;
    tready = rdy;
    if (rdy) pending = 1'b0;
    addr_ok = (a == 7'h50) && (rw == 1'b0);
    i2c_start();
    send_byte({a, rw}, ack);
    check("addr_ack", ack, addr_ok);
    ign = ~addr_ok;
    for (int i = 0; i < n; i++) begin
      if (ign) begin
        ea = 1'b0;
      end else if (rdy || !pending) begin
        exp_q.push_back('{data: d[i], user: (i == 0)});
        ea = 1'b1;
        if (!rdy) pending = 1'b1;
      end else begin
        ea = 1'b0;
        exp_ovf++;
        ign = 1'b1;
      end
      send_byte(d[i], ack);
      check("data_ack", ack, ea);
    end
    check("busy_before_stop", busy, addr_ok);
    i2c_stop();
    wq();
    check("busy_after_stop", busy, 0);
    check("overflow_count", ovf_seen, exp_ovf);
  endtask

  task automatic drain();
    int k = 0;
    tready  = 1'b1;
    pending = 1'b0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic ack;
    int   k;
    arst = 1'b1; scl = 1'b1; sda_m = 1'b1; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    arst = 1'b0;
    wq();

    // Basic write, address mismatch, read request.
    do_write(7'h50, 1'b0, 8'hA5, 8'h00, 8'h00, 1, 1'b1);
    drain();
    do_write(7'h51, 1'b0, 8'h3C, 8'h00, 8'h00, 1, 1'b1);
    do_write(7'h50, 1'b1, 8'h5A, 8'h00, 8'h00, 1, 1'b1);
    check("read_no_traffic", exp_q.size(), 0);

    // Output held with tready=0: second byte NACKed with overflow.
    do_write(7'h50, 1'b0, 8'h11, 8'h22, 8'h00, 2, 1'b0);
    check("held_tvalid", tvalid, 1);
    check("held_tdata", tdata, 8'h11);
    drain();

    // Repeated START after 4 data bits drops the partial byte.
    tready = 1'b1;
    i2c_start();
    send_byte(8'hA0, ack);
    check("rs_addr_ack1", ack, 1);
    send_bits(8'hB0, 4);
    i2c_start();
    send_byte(8'hA0, ack);
    check("rs_addr_ack2", ack, 1);
    exp_q.push_back('{data: 8'h7E, user: 1'b1});
    send_byte(8'h7E, ack);
    check("rs_data_ack", ack, 1);
    i2c_stop();
    drain();

    // Reset while the address ACK is being driven.
    i2c_start();
    send_bits(8'hA0, 8);
    k = 0;
    while (!sda_oe && k < 40) begin
      @(posedge clk);
      k++;
    end
    check("ack_driven_before_rst", sda_oe, 1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("arst_sda_oe", sda_oe, 0);
    check("arst_tvalid", tvalid, 0);
    check("arst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    ack_win = 1'b0;
    i2c_stop();
    do_write(7'h50, 1'b0, 8'h99, 8'h00, 8'h00, 1, 1'b1);
    drain();

`ifdef I2C_SLAVE_FILTER_EN
    glitch_next = 1'b1;
    do_write(7'h50, 1'b0, 8'hC3, 8'h00, 8'h00, 1, 1'b1);
    drain();
`endif

    // Randomized transactions; a pending beat may survive into the next one.
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      logic       rw, rdy;
      a   = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom);
      rw  = ($urandom_range(0, 4) == 0);
      rdy = $urandom_range(0, 1) == 1;
      do_write(a, rw, 8'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(1, 3)), rdy);
      if (!rdy && $urandom_range(0, 1) == 1) drain();
    end
    drain();
    wq();
    check("final_overflow_count", ovf_seen, exp_ovf);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
